fetch_pc_ctrl: RTL and testbench

- Fetch-stage PC controller directly upstream of the branch predictor.
- Holds the PC and supplies pc_1 (PC+1, word addressing) to the predictor.
- Selects the next PC from sequential, predicted-target and misprediction-redirect sources.
- Keeps a small in-order queue of in-flight branch predictions; drives the predictor's taken/not_taken update pulses and the pipeline flush when EX resolves a branch.

---
 rtl/fetch_pc_ctrl_if.sv | 30 +++
 rtl/fetch_pc_ctrl.sv | 109 ++++++++++
 tb/tb_fetch_pc_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage PC controller bus: branch/prediction/resolve inputs and PC/queue-status outputs.
interface fetch_pc_ctrl_if #(
  parameter int unsigned QAW = 2
);
  logic          stall_in;
  logic          branch;
  logic          pred_taken;
  logic [31:0]   pred_addr;
  logic          ex_valid;
  logic          ex_taken;
  logic [31:0]   pc;
  logic [31:0]   pc_1;
  logic          fetch_valid;
  logic          taken;
  logic          not_taken;
  logic          flush;
  logic          q_full;
  logic [QAW:0]  q_count;
  logic          q_err;

  modport master (
    output stall_in, branch, pred_taken, pred_addr, ex_valid, ex_taken,
    input  pc, pc_1, fetch_valid, taken, not_taken, flush, q_full, q_count, q_err
  );

  modport slave (
    input  stall_in, branch, pred_taken, pred_addr, ex_valid, ex_taken,
    output pc, pc_1, fetch_valid, taken, not_taken, flush, q_full, q_count, q_err
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: next-PC selection plus an in-order queue of in-flight
// branch predictions used to detect mispredicts and redirect fetch.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned QAW      = 2
) (
  input logic             clk,
  input logic             rst_n,
  fetch_pc_ctrl_if.slave  bus
);
  localparam logic [QAW:0] QFULL = (QAW+1)'(QDEPTH);

  logic [31:0]    pc_q;
  logic [QAW-1:0] head_q;
  logic [QAW-1:0] tail_q;
  logic [QAW:0]   count_q;
  logic           err_q;

  logic           pt_mem  [QDEPTH];
  logic [31:0]    alt_mem [QDEPTH];

  logic           q_nonempty;
  logic           pop;
  logic           mis;
  logic           qstall;
  logic           fetch_ok;
  logic           push;
  logic [31:0]    pc_inc;
  logic [31:0]    pc_nxt;
  logic [31:0]    alt_new;

  always_comb begin
    pc_inc     = pc_q + 32'd1;
    q_nonempty = (count_q != '0);
    pop        = bus.ex_valid & q_nonempty;
    mis        = pop & (bus.ex_taken != pt_mem[head_q]);
    // A same-cycle pop frees a slot, so a full queue only stalls without one.
    qstall     = bus.branch & (count_q == QFULL) & ~pop;
    fetch_ok   = ~bus.stall_in & ~qstall & ~mis;
    push       = bus.branch & fetch_ok;
    alt_new    = bus.pred_taken ? pc_inc : bus.pred_addr;

    if (mis) begin
      pc_nxt = alt_mem[head_q];
    end else if (!fetch_ok) begin
      pc_nxt = pc_q;
    end else if (bus.branch && bus.pred_taken) begin
      pc_nxt = bus.pred_addr;
    end else begin
      pc_nxt = pc_inc;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_1        = pc_inc;
  assign bus.fetch_valid = fetch_ok;
  assign bus.taken       = bus.ex_valid & bus.ex_taken;
  assign bus.not_taken   = bus.ex_valid & ~bus.ex_taken;
  assign bus.flush       = mis;
  assign bus.q_full      = (count_q == QFULL);
  assign bus.q_count     = count_q;
  assign bus.q_err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q <= pc_nxt;
      if (bus.ex_valid && !q_nonempty) begin
        err_q <= 1'b1;
      end
    end
  end

  // Mispredict flushes younger instructions, so the whole queue is dropped
  // and the push it suppresses never happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (mis) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + QAW'(1);
      end
      if (pop) begin
        head_q <= head_q + QAW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (QAW+1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (QAW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pt_mem[tail_q]  <= bus.pred_taken;
      alt_mem[tail_q] <= alt_new;
    end
  end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: a queue-based reference model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_fetch_pc_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_ctrl_if #(.QAW(2)) bus ();

  fetch_pc_ctrl #(.RESET_PC(RST_PC), .QDEPTH(4), .QAW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_1;
    logic        fv;
    logic        tk;
    logic        ntk;
    logic        fl;
    logic        full;
    logic [2:0]  cnt;
    logic        err;
  } exp_t;

  typedef struct {
    logic        pt;
    logic [31:0] alt;
  } ent_t;

  exp_t        exp_q[$];
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_err;
  int          n_cmp = 0;
  int          n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",          bus.pc,          e.pc);
        chk("pc_1",        bus.pc_1,        e.pc_1);
        chk("fetch_valid", 32'(bus.fetch_valid), 32'(e.fv));
        chk("taken",       32'(bus.taken),       32'(e.tk));
        chk("not_taken",   32'(bus.not_taken),   32'(e.ntk));
        chk("flush",       32'(bus.flush),       32'(e.fl));
        chk("q_full",      32'(bus.q_full),      32'(e.full));
        chk("q_count",     32'(bus.q_count),     32'(e.cnt));
        chk("q_err",       32'(bus.q_err),       32'(e.err));
      end
    end
  end

  task automatic idle_inputs();
    bus.stall_in   = 1'b0;
    bus.branch     = 1'b0;
    bus.pred_taken = 1'b0;
    bus.pred_addr  = '0;
    bus.ex_valid   = 1'b0;
    bus.ex_taken   = 1'b0;
  endtask

  // One cycle: apply inputs, predict outputs, advance the model across the edge.
  task automatic cyc(input logic st, input logic br, input logic pt,
                     input logic [31:0] pa, input logic exv, input logic ext);
    exp_t e;
    ent_t n;
    int   cnt;
    logic pop, mis, fv;
    bus.stall_in   = st;
    bus.branch     = br;
    bus.pred_taken = pt;
    bus.pred_addr  = pa;
    bus.ex_valid   = exv;
    bus.ex_taken   = ext;
    cnt = mq.size();
    pop = exv && (cnt > 0);
    mis = 1'b0;
    if (pop) mis = (ext != mq[0].pt);
    fv = !st && !(br && (cnt == 4) && !pop) && !mis;
    e.pc   = m_pc;
    e.pc_1 = m_pc + 32'd1;
    e.fv   = fv;
    e.tk   = exv && ext;
    e.ntk  = exv && !ext;
    e.fl   = mis;
    e.full = (cnt == 4);
    e.cnt  = 3'(cnt);
    e.err  = m_err;
    exp_q.push_back(e);
    if (exv && cnt == 0) m_err = 1'b1;
    if (mis) begin
      m_pc = mq[0].alt;
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (fv) begin
        if (br) begin
          n.pt  = pt;
          n.alt = pt ? m_pc + 32'd1 : pa;
          mq.push_back(n);
        end
        m_pc = (br && pt) ? pa : m_pc + 32'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Reset asserted between edges; the monitor checks it before any clock edge.
  task automatic do_reset();
    exp_t e;
    idle_inputs();
    #2;
    rst_n = 1'b0;
    m_pc  = RST_PC;
    m_err = 1'b0;
    mq.delete();
    e.pc = RST_PC; e.pc_1 = RST_PC + 32'd1; e.fv = 1'b1; e.tk = 1'b0; e.ntk = 1'b0;
    e.fl = 1'b0; e.full = 1'b0; e.cnt = '0; e.err = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle_until(input logic [31:0] target);
    for (int i = 0; i < 64 && m_pc != target; i++) cyc(0, 0, 0, '0, 0, 0);
  endtask

  task automatic rand_cycles(input int n);
    logic exv;
    for (int i = 0; i < n; i++) begin
      exv = (mq.size() > 0) ? ($urandom % 3 == 0) : ($urandom % 50 == 0);
      cyc(($urandom % 8) == 0, ($urandom % 3) == 0, 1'($urandom), $urandom, exv, 1'($urandom));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    m_pc = RST_PC; m_err = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    idle_until(32'd5);
    cyc(0, 1, 1, 32'h40, 0, 0);          // taken prediction, alt = 6
    cyc(0, 0, 0, '0, 0, 0);
    cyc(0, 0, 0, '0, 1, 0);              // mispredict -> pc 6
    idle_until(32'd8);
    cyc(0, 1, 0, 32'h20, 0, 0);          // not-taken prediction, alt = 0x20
    cyc(0, 0, 0, '0, 0, 0);
    cyc(0, 0, 0, '0, 1, 1);              // mispredict -> pc 0x20
    cyc(0, 1, 1, 32'h100, 0, 0);
    cyc(0, 0, 0, '0, 1, 1);              // correct: pop only
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, $urandom, 0, 0);
    cyc(0, 1, 0, 32'h500, 0, 0);         // full: held
    cyc(0, 1, 0, 32'h500, 1, 0);         // correct pop frees slot, push accepted
    cyc(1, 0, 0, '0, 1, 1);              // mispredict during stall still redirects
    cyc(0, 0, 0, '0, 0, 0);
    cyc(0, 0, 0, '0, 1, 0);              // resolve on empty queue
    cyc(0, 0, 0, '0, 0, 0);
    cyc(0, 0, 0, '0, 0, 0);
    cyc(0, 1, 1, 32'hFFFF_FFFF, 0, 0);
    cyc(0, 0, 0, '0, 0, 0);              // pc_1 wraps to 0
    cyc(0, 0, 0, '0, 0, 0);
    do_reset();
    rand_cycles(1500);
    do_reset();
    rand_cycles(500);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
